// File: rtl/pinsert_stream.sv
// Byte-stream framer: emits the 4-byte PATTERN (MSB byte first) ahead of every
// FRAME_LEN payload bytes, with one registered output stage and valid/ready handshakes on both sides.
module pinsert_stream #(
    parameter logic [31:0] PATTERN   = 32'h0000_ABCD,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_m_data,
    input  logic       i_m_valid,
    output logic       o_m_ready,
    output logic [7:0] o_s_data,
    output logic       o_s_valid,
    input  logic       i_s_ready,
    output logic       o_s_sync
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        SYNC      = 2'd1,
        PAYLOAD   = 2'd2
    } state_t;

    state_t           state_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       data_r;
    logic             valid_r;
    logic             sync_r;

    logic             adv_s;
    logic             m_ready_s;
    logic             in_xfer_s;
    logic             last_s;

    // Select one byte of the sync word; index 3 is the first byte on the wire.
    function automatic logic [7:0] pattern_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd3:    b = PATTERN[31:24];
            2'd2:    b = PATTERN[23:16];
            2'd1:    b = PATTERN[15:8];
            2'd0:    b = PATTERN[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Handshake decode: the output register may load whenever it is empty or being drained.
    always_comb begin
        adv_s     = !valid_r || i_s_ready;
        m_ready_s = 1'b0;
        if (state_r == PAYLOAD) begin
            m_ready_s = adv_s;
        end else begin
            m_ready_s = 1'b0;
        end
        in_xfer_s = i_m_valid && m_ready_s;
        last_s    = (cnt_r == CNT_W'(FRAME_LEN - 1));
    end

    // Framing FSM and registered output stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= SYNC_WAIT;
            idx_r   <= 2'd3;
            cnt_r   <= {CNT_W{1'b0}};
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            case (state_r)
                SYNC_WAIT: begin
                    // A pattern only starts once payload is actually pending.
                    if (i_m_valid && adv_s) begin
                        data_r  <= pattern_byte(2'd3);
                        valid_r <= 1'b1;
                        sync_r  <= 1'b1;
                        idx_r   <= 2'd2;
                        state_r <= SYNC;
                    end else if (adv_s) begin
                        valid_r <= 1'b0;
                        sync_r  <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                SYNC: begin
                    if (adv_s) begin
                        data_r  <= pattern_byte(idx_r);
                        valid_r <= 1'b1;
                        sync_r  <= 1'b1;
                        if (idx_r == 2'd0) begin
                            idx_r   <= 2'd3;
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= PAYLOAD;
                        end else begin
                            idx_r <= idx_r - 2'd1;
                        end
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                PAYLOAD: begin
                    if (in_xfer_s) begin
                        data_r  <= i_m_data;
                        valid_r <= 1'b1;
                        sync_r  <= 1'b0;
                        if (last_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= SYNC_WAIT;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else if (adv_s) begin
                        // Source bubble: drop valid, leave the data bits alone.
                        valid_r <= 1'b0;
                        sync_r  <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    state_r <= SYNC_WAIT;
                    idx_r   <= 2'd3;
                    cnt_r   <= {CNT_W{1'b0}};
                    valid_r <= 1'b0;
                    sync_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_m_ready = m_ready_s;
    assign o_s_data  = data_r;
    assign o_s_valid = valid_r;
    assign o_s_sync  = sync_r;

endmodule

// File: tb/tb_pinsert_stream.sv
// Directed vector table plus reset and randomized loopback checks for pinsert_stream
// (FRAME_LEN=4, PATTERN=32'h0000ABCD, i.e. wire bytes 00,00,AB,CD).
module tb_pinsert_stream;

    localparam int          FL  = 4;
    localparam logic [31:0] PAT = 32'h0000_ABCD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_sync;

    always #5 clk = ~clk;

    pinsert_stream #(.PATTERN(PAT), .FRAME_LEN(FL)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_m_data (m_data),
        .i_m_valid(m_valid),
        .o_m_ready(m_ready),
        .o_s_data (s_data),
        .o_s_valid(s_valid),
        .i_s_ready(s_ready),
        .o_s_sync (s_sync)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mv;
        logic [7:0] md;
        logic       sr;
        logic       mr;
        logic       sv;
        logic [7:0] sd;
        logic       ss;
    } vec_t;

    function automatic vec_t mk(input logic mv, input logic [7:0] md, input logic sr,
                                input logic mr, input logic sv, input logic [7:0] sd, input logic ss);
        vec_t v;
        v.mv = mv; v.md = md; v.sr = sr; v.mr = mr; v.sv = sv; v.sd = sd; v.ss = ss;
        return v;
    endfunction

    vec_t       vecs[29];
    logic [7:0] rexp[5];
    logic [7:0] q[$];
    logic [31:0] patv;
    logic [31:0] win;
    logic [7:0] src;
    logic [7:0] xd;
    logic       ix, ox, xs;
    int         sent, pos, frames, cyc;

    initial begin
        // inputs: mv md sr | expected: m_ready (pre-edge), s_valid s_data s_sync (post-edge)
        vecs[0]  = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[1]  = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[2]  = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1);
        vecs[3]  = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b1);
        vecs[4]  = mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0);
        vecs[5]  = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        vecs[6]  = mk(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
        vecs[7]  = mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0);
        vecs[8]  = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[9]  = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[10] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1);
        vecs[11] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b1);
        vecs[12] = mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        vecs[13] = mk(1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0);
        // source stall mid-payload: one bubble, data held, no sync
        vecs[14] = mk(1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0);
        vecs[15] = mk(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        vecs[16] = mk(1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 8'h88, 1'b0);
        // idle gap: no sync bytes while nothing is pending
        vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h88, 1'b0);
        vecs[18] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h88, 1'b0);
        vecs[19] = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[20] = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        vecs[21] = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1);
        // backpressure while AB is presented
        vecs[22] = mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        vecs[23] = mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        vecs[24] = mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        vecs[25] = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b1);
        vecs[26] = mk(1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
        vecs[27] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        vecs[28] = mk(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);

        rst     = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        s_ready = 1'b1;
        #12;
        check("rst.s_valid", {31'd0, s_valid}, 32'd0);
        check("rst.s_data",  {24'd0, s_data},  32'd0);
        check("rst.s_sync",  {31'd0, s_sync},  32'd0);
        check("rst.m_ready", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            m_valid = vecs[i].mv;
            m_data  = vecs[i].md;
            s_ready = vecs[i].sr;
            #1;
            check($sformatf("v%0d.m_ready", i), {31'd0, m_ready}, {31'd0, vecs[i].mr});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d.s_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].sv});
            check($sformatf("v%0d.s_data", i),  {24'd0, s_data},  {24'd0, vecs[i].sd});
            check($sformatf("v%0d.s_sync", i),  {31'd0, s_sync},  {31'd0, vecs[i].ss});
        end

        // Async reset between edges after two payload bytes (99, AA) of the current frame
        #2 rst = 1'b1;
        #1;
        check("arst.s_valid", {31'd0, s_valid}, 32'd0);
        check("arst.s_data",  {24'd0, s_data},  32'd0);
        check("arst.s_sync",  {31'd0, s_sync},  32'd0);
        check("arst.m_ready", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rexp[0] = 8'h00; rexp[1] = 8'h00; rexp[2] = 8'hAB; rexp[3] = 8'hCD; rexp[4] = 8'hBB;
        for (int i = 0; i < 5; i++) begin
            m_valid = 1'b1;
            m_data  = 8'hBB;
            s_ready = 1'b1;
            #1;
            check($sformatf("rs%0d.m_ready", i), {31'd0, m_ready}, (i == 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rs%0d.s_valid", i), {31'd0, s_valid}, 32'd1);
            check($sformatf("rs%0d.s_data", i),  {24'd0, s_data},  {24'd0, rexp[i]});
            check($sformatf("rs%0d.s_sync", i),  {31'd0, s_sync},  (i < 4) ? 32'd1 : 32'd0);
        end

        // Loopback: random handshakes, detector window plus payload scoreboard
        m_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        patv = PAT; win = 32'hFFFF_FFFF; src = 8'h10;
        sent = 0; pos = 0; frames = 0; cyc = 0;
        while (cyc < 40000 && !(sent == 100 * FL && q.size() == 0 && frames == 100)) begin
            @(negedge clk);
            cyc++;
            m_valid = (sent < 100 * FL) && ($urandom_range(0, 3) != 0);
            m_data  = src;
            s_ready = ($urandom_range(0, 3) != 0);
            #1;
            ix = m_valid && m_ready;
            ox = s_valid && s_ready;
            xd = s_data;
            xs = s_sync;
            if (ix) begin
                q.push_back(src);
                src = (src == 8'h7F) ? 8'h10 : src + 8'd1;
                sent++;
            end
            if (ox) begin
                win = {win[23:0], xd};
                if (pos < 4) begin
                    check("lb.sync_hi", {31'd0, xs}, 32'd1);
                    check("lb.pattern", {24'd0, xd}, {24'd0, patv[8*(3-pos) +: 8]});
                end else begin
                    check("lb.sync_lo", {31'd0, xs}, 32'd0);
                    if (q.size() == 0) begin
                        check("lb.underflow", 32'd1, 32'd0);
                    end else begin
                        check("lb.payload", {24'd0, xd}, {24'd0, q.pop_front()});
                    end
                end
                if (win == patv) begin
                    frames++;
                    check("lb.detect_pos", pos, 32'd3);
                end
                pos = (pos == FL + 3) ? 0 : pos + 1;
            end
        end
        check("lb.timeout", (cyc < 40000) ? 32'd1 : 32'd0, 32'd1);
        check("lb.frames", frames, 32'd100);
        check("lb.leftover", q.size(), 32'd0);
        check("lb.frame_end", pos, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pinsert_stream.md
Name: pinsert_stream

Overview:
- Transmit-side companion to the stream pattern detector: a byte-stream framer that inserts a 32-bit sync PATTERN ahead of every FRAME_LEN payload bytes.
- Sits between a payload source (manager) and the link/sink (subordinate). A downstream pattern detector configured with the same PATTERN locks onto every frame boundary.
- Uses a single registered output stage with a valid/ready handshake on both sides.

Parameters:
- PATTERN, 32'hABCD: sync word, transmitted MSB byte first (PATTERN[31:24], [23:16], [15:8], [7:0]).
- FRAME_LEN, 16: payload bytes per frame; legal range >= 1. Counter width is $clog2(FRAME_LEN+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m_data  in  8  payload byte from manager.
- i_m_valid  in  1  payload byte valid.
- o_m_ready  out  1  block accepts payload byte; combinational.
- o_s_data  out  8  framed output byte; registered.
- o_s_valid  out  1  output byte valid; registered.
- i_s_ready  in  1  subordinate accepts output byte.
- o_s_sync  out  1  registered; high when o_s_data is a PATTERN byte.

Behaviour:
- Transfers:
  - Output advance condition: adv = !o_s_valid || i_s_ready. The output register loads only when adv=1.
  - An input transfer is i_m_valid && o_m_ready.
  - An output transfer is o_s_valid && i_s_ready.
- Reset, asynchronous, on any cycle including mid-frame:
  - o_s_valid=0, o_s_data=0, o_s_sync=0; state=SYNC_WAIT; sync index=3; payload count=0. Any partial frame is discarded.
  - After reset deassertion the next frame starts with a full PATTERN.
- State SYNC_WAIT:
  - o_m_ready=0.
  - If i_m_valid=1 and adv=1: load o_s_data=PATTERN[31:24], o_s_valid=1, o_s_sync=1, index=2, go to SYNC.
  - Otherwise hold. No sync bytes are emitted while no payload is pending.
- State SYNC:
  - o_m_ready=0.
  - On each adv=1: load PATTERN byte[index] with o_s_valid=1 and o_s_sync=1, then decrement index.
  - After loading byte[0]: reset index to 3, clear count to 0, go to PAYLOAD.
  - Once started, the pattern always completes. A drop of i_m_valid does not abort it.
- State PAYLOAD:
  - o_m_ready = adv.
  - On an input transfer: o_s_data=i_m_data, o_s_valid=1, o_s_sync=0, count+1.
  - When the transfer makes count==FRAME_LEN: go to SYNC_WAIT and clear count.
  - adv=1 with no input transfer: clear o_s_valid, keep o_s_data unchanged, stay in PAYLOAD.
- Backpressure: when o_s_valid=1 and i_s_ready=0, o_s_data, o_s_valid and o_s_sync are held stable and no state changes occur.
- Latency: one cycle from input transfer (or sync load) to o_s_valid. With i_s_ready held high, throughput is 1 byte/cycle.
  - Sustained efficiency is FRAME_LEN/(FRAME_LEN+4).
  - No bubble between the last sync byte and the first payload byte, or between the last payload byte and the next pattern when i_m_valid=1.
- Simultaneous events: when an output transfer and a new load coincide (i_s_ready=1, o_s_valid=1), the register reloads in the same cycle with no bubble.
- Data integrity: payload bytes are never modified, dropped or reordered. Exactly 4 sync bytes precede every FRAME_LEN payload bytes.

Test Plan:
- Basic frame: FRAME_LEN=4, i_s_ready=1, source offers 11,22,33,44,55,... continuously -> output 00,00,AB,CD,11,22,33,44,00,00,AB,CD,55,...
  - o_s_sync=1 exactly on the pattern bytes.
  - Back-to-back with o_s_valid=1 every cycle after the first.
- Idle gap: i_m_valid=0 after a frame ends -> no sync bytes emitted, o_s_valid=0.
  - On i_m_valid reassertion, 00 appears one cycle later, followed by the rest of the pattern.
- Backpressure: i_s_ready=0 for 3 cycles while o_s_data=AB -> AB, o_s_valid=1 and o_s_sync=1 stay stable, o_m_ready=0.
  - On resume, CD follows and then payload continues with no byte lost.
- Source stall mid-payload: i_m_valid toggles 1,0,1 during PAYLOAD -> one bubble (o_s_valid=0) and no sync inserted.
  - Payload count continues, so the frame still holds exactly FRAME_LEN bytes.
- Async reset mid-frame: assert i_rst between clock edges after 2 payload bytes -> outputs clear immediately (o_s_valid=0).
  - After release, output restarts at 00,00,AB,CD.
- Loopback: drive output into a pattern detector configured with PATTERN=32'hABCD, random i_s_ready and i_m_valid, 100 frames -> detected asserts once per frame.
  - Scoreboard confirms payload order and count.
